// File: rtl/dpram_port_arb.sv
// dpram_port_arb
// Shares one 32-bit port of the dual-port RAM between two requesters.
// Requester 0 is the core load/store path. Requester 1 is the debug/DMA path.
// After reset, an optional sequencer zero-fills the whole RAM.
// No requester is served until that fill has finished.
//
// Parameters
//   RAM_DEPTH  number of RAM words; AW is the dpram address width
//   CLR_EN     1: zero-fill all words after reset, 0: serve requesters at once
//   FIX_PRI    0: round-robin on conflict, 1: m0 always wins a conflict
//
// Ports
//   clk, rst                  single clock, synchronous active-high reset
//   mX_req/we/wem/addr/wdata  requester X access (req held until mX_gnt)
//   mX_gnt                    request accepted this cycle (combinational)
//   mX_rvalid/rdata           read data, one cycle after a read grant
//   ram_en/we/wem/addr/din    drive to the dpram port
//   ram_dout                  dpram read data (1-cycle latency)
//   init_done                 high once the fill is complete
module dpram_port_arb #(
  parameter int RAM_DEPTH = 2048,
  parameter bit CLR_EN    = 1'b1,
  parameter bit FIX_PRI   = 1'b0,
  localparam int AW       = (RAM_DEPTH > 2) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [3:0]    m0_wem,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [3:0]    m1_wem,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [3:0]    ram_wem,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_din,
  input  logic [31:0]   ram_dout,
  output logic          init_done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] clr_addr;
  logic          last;
  logic          rvalid0_q;
  logic          rvalid1_q;
  logic          run;
  logic          m0_wins_conflict;

  // The state register.
  // Reset goes to CLEAR when the fill is enabled, and straight to RUN otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLR_EN ? ST_CLEAR : ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  // The write to the top word is the final fill cycle.
  // The cycle after that write is RUN.
  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && clr_addr == LAST_ADDR) begin
      state_nxt = ST_RUN;
    end
  end

  // Fill address counter.
  // Any reset restarts the fill from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr <= '0;
    end else if (state == ST_CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
    end
  end

  // Grant decision.
  // The decision is combinational, so a requester sees its grant in the
  // same cycle it asks.
  // Grants are held off while reset is asserted and while the fill is running.
  // On a conflict, m0 wins under fixed priority, or when m1 was the most
  // recent winner.
  always_comb begin
    run              = (state == ST_RUN) && !rst;
    m0_wins_conflict = FIX_PRI || last;
    m0_gnt           = run && m0_req && (!m1_req || m0_wins_conflict);
    m1_gnt           = run && m1_req && !(m0_req && m0_wins_conflict);
  end

  // RAM port drive.
  // During the fill, the block writes zeros to every byte of each word.
  // In RUN, the winner's access is forwarded unchanged.
  // In idle cycles, the port is left disabled so dout holds its last value.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_wem  = 4'h0;
    ram_addr = '0;
    ram_din  = 32'h0;
    if (state == ST_CLEAR) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_wem  = 4'hF;
      ram_addr = clr_addr;
    end else if (m0_gnt) begin
      ram_en   = 1'b1;
      ram_we   = m0_we;
      ram_wem  = m0_wem;
      ram_addr = m0_addr;
      ram_din  = m0_wdata;
    end else if (m1_gnt) begin
      ram_en   = 1'b1;
      ram_we   = m1_we;
      ram_wem  = m1_wem;
      ram_addr = m1_addr;
      ram_din  = m1_wdata;
    end
  end

  // Round-robin history and read-valid pipeline.
  // 'last' only moves on a grant.
  // Its reset value of 1 lets m0 take the first conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      last      <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      if (m0_gnt) begin
        last <= 1'b0;
      end else if (m1_gnt) begin
        last <= 1'b1;
      end
      rvalid0_q <= m0_gnt && !m0_we;
      rvalid1_q <= m1_gnt && !m1_we;
    end
  end

  // Read return.
  // Data is shared by both requesters, and only the valid flags are
  // per-requester.
  // Reset masks a pending valid in the same cycle, so a read that was
  // granted just before reset never reports.
  always_comb begin
    m0_rvalid = rvalid0_q && !rst;
    m1_rvalid = rvalid1_q && !rst;
    m0_rdata  = ram_dout;
    m1_rdata  = ram_dout;
    init_done = (state == ST_RUN);
  end

endmodule

// File: tb/tb_dpram_port_arb.sv
// Testbench for dpram_port_arb.
// Main instance: RAM_DEPTH=16, CLR_EN=1, round-robin, backed by a
// behavioural dpram model.
// Second instance: fixed priority, no fill. It shares the main instance's
// requester inputs and is only checked for its grant pattern.
module tb_dpram_port_arb;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [3:0]    m0_wem, m1_wem;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          ram_en, ram_we;
  logic [3:0]    ram_wem;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din, ram_dout;
  logic          init_done;

  logic          fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid;
  logic [31:0]   fp_m0_rdata, fp_m1_rdata;
  logic          fp_ram_en, fp_ram_we;
  logic [3:0]    fp_ram_wem;
  logic [AW-1:0] fp_ram_addr;
  logic [31:0]   fp_ram_din;
  logic [31:0]   fp_ram_dout;
  logic          fp_init_done;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   q0[$];
  logic [31:0]   q1[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  assign fp_ram_dout = 32'h0;

  dpram_port_arb #(.RAM_DEPTH(DEPTH), .CLR_EN(1'b1), .FIX_PRI(1'b0)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_wem(m0_wem), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wem(m1_wem), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_wem(ram_wem), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .init_done(init_done)
  );

  dpram_port_arb #(.RAM_DEPTH(DEPTH), .CLR_EN(1'b0), .FIX_PRI(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_wem(m0_wem), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wem(m1_wem), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
    .ram_en(fp_ram_en), .ram_we(fp_ram_we), .ram_wem(fp_ram_wem), .ram_addr(fp_ram_addr),
    .ram_din(fp_ram_din), .ram_dout(fp_ram_dout), .init_done(fp_init_done)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dpram port model.
  // Reads have one cycle of latency, and dout holds its value while the
  // port is idle.
  // Every word is preloaded with all ones, so that the fill is visible.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hFFFF_FFFF;
    ram_dout = 32'h0;
  end

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  // Compare one value, and count the comparison and any failure.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  // Every read valid must match the oldest expected word for that requester.
  // A valid that arrives with nothing expected is an error.
  always @(negedge clk) begin
    if (m0_rvalid) begin
      if (q0.size() == 0) checkOutput("m0_unexpected_rvalid", 32'd1, 32'd0);
      else checkOutput("m0_rdata", m0_rdata, q0.pop_front());
    end
    if (m1_rvalid) begin
      if (q1.size() == 0) checkOutput("m1_unexpected_rvalid", 32'd1, 32'd0);
      else checkOutput("m1_rdata", m1_rdata, q1.pop_front());
    end
  end

  // Issue one access and hold the request until it is granted.
  // For reads, the hand-computed word is queued for the monitor.
  // Call at #1 after a rising edge. The task returns at the same phase.
  task automatic applyStimulus(input bit port, input logic we, input logic [3:0] wem,
                               input logic [AW-1:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata);
    bit granted = 1'b0;
    if (port == 1'b0) begin
      m0_req = 1'b1; m0_we = we; m0_wem = wem; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_wem = wem; m1_addr = addr; m1_wdata = wdata;
    end
    for (int c = 0; c < 20 && !granted; c++) begin
      @(negedge clk);
      if ((port == 1'b0 && m0_gnt) || (port == 1'b1 && m1_gnt)) begin
        granted = 1'b1;
        checkOutput("gnt_exclusive", port ? m0_gnt : m1_gnt, 32'd0);
        if (!we) begin
          if (port == 1'b0) q0.push_back(exp_rdata);
          else q1.push_back(exp_rdata);
        end
      end
      @(posedge clk); #1;
    end
    checkOutput("gnt_seen", granted, 32'd1);
    if (port == 1'b0) m0_req = 1'b0;
    else m1_req = 1'b0;
    if (granted && !we) checkOutput("rvalid_latency", port ? m1_rvalid : m0_rvalid, 32'd1);
  endtask

  // Walk n fill cycles, starting at #1 after the edge where reset was
  // released.
  // Each fill cycle addresses the next word, and no grant is given.
  task automatic runFill(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      checkOutput("fill_init_done", init_done, 32'd0);
      checkOutput("fill_no_gnt", {m0_gnt, m1_gnt}, 32'd0);
      checkOutput("fill_addr", ram_addr, c);
      checkOutput("fill_write", {ram_en, ram_we, ram_wem}, 32'h3F);
      if (c < n - 1 || n == DEPTH) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Main stimulus sequence.
  initial begin
    logic [5:0] rr_m0_exp;
    logic [5:0] rr_m1_exp;
    bit         seen;
    rr_m0_exp = 6'b010101;
    rr_m1_exp = 6'b101010;

    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_wem = 4'h0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_wem = 4'h0; m1_addr = '0; m1_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", {init_done, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 32'd0);
    checkOutput("reset_fp_init_done", fp_init_done, 32'd1);

    // Zero fill while both requesters wait with pending reads.
    rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 4'd0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 4'd1;
    runFill(DEPTH);
    @(negedge clk);
    checkOutput("init_done_after_fill", init_done, 32'd1);
    checkOutput("first_conflict_m0", {m0_gnt, m1_gnt}, 32'b10);
    q0.push_back(32'h0);
    @(posedge clk); #1;
    m0_req = 1'b0;
    @(negedge clk);
    checkOutput("pending_m1_gnt", {m0_gnt, m1_gnt}, 32'b01);
    q1.push_back(32'h0);
    @(posedge clk); #1;
    m1_req = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'h0, 4'd15, 32'h0, 32'h0);

    // Write then read back.
    applyStimulus(1'b0, 1'b1, 4'hF, 4'd5, 32'hDEAD_BEEF, 32'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'd5, 32'h0, 32'hDEAD_BEEF);

    // Byte-masked merge.
    // A write with an all-zero mask must leave the word unchanged.
    applyStimulus(1'b0, 1'b1, 4'hF, 4'd3, 32'h1122_3344, 32'h0);
    applyStimulus(1'b0, 1'b1, 4'b0101, 4'd3, 32'hAABB_CCDD, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd3, 32'h0, 32'h11BB_33DD);
    applyStimulus(1'b0, 1'b1, 4'h0, 4'd5, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'd3, 32'h0, 32'h11BB_33DD);
    applyStimulus(1'b0, 1'b0, 4'h0, 4'd5, 32'h0, 32'hDEAD_BEEF);
    // The m1 read makes m1 the most recent winner.
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd5, 32'h0, 32'hDEAD_BEEF);

    // Sustained conflict.
    // Both requesters write with an empty mask, so the RAM is not disturbed.
    m0_req = 1'b1; m0_we = 1'b1; m0_wem = 4'h0; m0_addr = 4'd8;
    m1_req = 1'b1; m1_we = 1'b1; m1_wem = 4'h0; m1_addr = 4'd9;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("rr_m0_gnt", m0_gnt, rr_m0_exp[i]);
      checkOutput("rr_m1_gnt", m1_gnt, rr_m1_exp[i]);
      checkOutput("fp_m0_gnt", fp_m0_gnt, 32'd1);
      checkOutput("fp_m1_gnt", fp_m1_gnt, 32'd0);
      @(posedge clk); #1;
    end
    m0_req = 1'b0; m1_req = 1'b0;

    // Reset in fill cycle 7 restarts the fill at word 0.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    runFill(8);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    runFill(DEPTH);
    @(negedge clk);
    checkOutput("init_done_after_refill", init_done, 32'd1);

    // Reset in the cycle after a read grant drops the read valid.
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 4'd0;
    @(negedge clk);
    checkOutput("drop_read_gnt", m0_gnt, 32'd1);
    @(posedge clk); #1;
    m0_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("drop_rvalid_in_reset", m0_rvalid, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("drop_rvalid_after_reset", m0_rvalid, 32'd0);

    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      seen = init_done;
    end
    checkOutput("final_init_done", seen, 32'd1);
    checkOutput("sb_q0_drained", q0.size(), 32'd0);
    checkOutput("sb_q1_drained", q1.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
